// File: rtl/dipsw_debounce.sv
// Per-bit two-flop synchronizer and stability-counter debouncer for DIP switches.
// Emits a clean level plus registered one-cycle rise/fall pulses.
module dipsw_debounce #(
    parameter int               WIDTH         = 4,
    parameter int               STABLE_CYCLES = 50000,
    parameter int               CNT_WIDTH     = 16,
    parameter logic [WIDTH-1:0] INVERT        = '0,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]     s1;
    logic [WIDTH-1:0]     s2;
    logic [CNT_WIDTH-1:0] cnt     [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0]     out_nxt;
    logic [WIDTH-1:0]     rise_nxt;
    logic [WIDTH-1:0]     fall_nxt;
    logic                 changed_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
        end else begin
            s1 <= sw_in ^ INVERT;
            s2 <= s1;
        end
    end

    // Any bounce back to the current level drops all accumulated credit.
    always_comb begin
        out_nxt  = sw_out;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != sw_out[i]) begin
                if (cnt[i] == LAST) begin
                    out_nxt[i]  = s2[i];
                    rise_nxt[i] = s2[i];
                    fall_nxt[i] = ~s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
        changed_nxt = |(rise_nxt | fall_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_out  <= RESET_VAL;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_out  <= out_nxt;
            rise    <= rise_nxt;
            fall    <= fall_nxt;
            changed <= changed_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_dipsw_debounce.sv
// Scoreboard bench for dipsw_debounce: directed stimulus pushes expected
// acceptance events; a negedge monitor pops them whenever changed is high.
module tb_dipsw_debounce;

    typedef struct {
        int         cyc;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rst_b;
    logic [3:0] sw_in;
    logic [3:0] sw_in_b;
    logic [3:0] sw_out, rise, fall;
    logic [3:0] sw_out_b, rise_b, fall_b;
    logic       changed, changed_b;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [3:0] lvl [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dipsw_debounce #(
        .WIDTH(4), .STABLE_CYCLES(4), .CNT_WIDTH(16),
        .INVERT(4'h0), .RESET_VAL(4'h0)
    ) dut (
        .clk(clk), .reset(reset), .sw_in(sw_in),
        .sw_out(sw_out), .rise(rise), .fall(fall), .changed(changed)
    );

    dipsw_debounce #(
        .WIDTH(4), .STABLE_CYCLES(4), .CNT_WIDTH(16),
        .INVERT(4'hF), .RESET_VAL(4'h0)
    ) dut_inv (
        .clk(clk), .reset(rst_b), .sw_in(sw_in_b),
        .sw_out(sw_out_b), .rise(rise_b), .fall(fall_b), .changed(changed_b)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [3:0] o,
                        input logic [3:0] r, input logic [3:0] f);
        exp_t e;
        e = '{cyc + 6, o, r, f};
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon(input int id, input logic r, input logic [3:0] o,
                       input logic [3:0] ri, input logic [3:0] fa,
                       input logic ch);
        exp_t e;
        bit   empty;
        if (r) begin
            lvl[id] = 4'h0;
        end else if (ch) begin
            empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
            chk($sformatf("u%0d_unexpected_change", id), 32'(empty), 32'd0);
            if (!empty) begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("u%0d_event_cycle", id), e.cyc >= 0 ? cyc : 0, e.cyc);
                chk($sformatf("u%0d_sw_out", id), 32'(o), 32'(e.out));
                chk($sformatf("u%0d_rise", id), 32'(ri), 32'(e.rise));
                chk($sformatf("u%0d_fall", id), 32'(fa), 32'(e.fall));
                lvl[id] = e.out;
            end
        end else begin
            chk($sformatf("u%0d_idle", id), {20'h0, o, ri, fa}, {20'h0, lvl[id], 8'h00});
        end
    endtask

    always @(negedge clk) begin
        mon(0, reset, sw_out, rise, fall, changed);
        mon(1, rst_b, sw_out_b, rise_b, fall_b, changed_b);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        rst_b   = 1'b1;
        sw_in   = 4'hF;
        sw_in_b = 4'h0;
        lvl[0]  = 4'h0;
        lvl[1]  = 4'h0;

        // reset values, then release with all switches on
        step(3);
        chk("reset_outputs", {19'h0, sw_out, rise, fall, changed}, 32'h0);
        reset = 1'b0;
        push(0, 4'hF, 4'hF, 4'h0);
        step(8);

        // asynchronous clear mid-cycle, then full requalification
        reset = 1'b1;
        #1;
        chk("async_reset", {19'h0, sw_out, rise, fall, changed}, 32'h0);
        step(2);
        reset = 1'b0;
        push(0, 4'hF, 4'hF, 4'h0);
        step(8);

        // clean steps
        sw_in = 4'h0;
        push(0, 4'h0, 4'h0, 4'hF);
        step(8);
        sw_in = 4'h1;
        push(0, 4'h1, 4'h1, 4'h0);
        step(8);

        // bounce on bit 1: high 3, low 1, then held high
        sw_in = 4'h3;
        step(3);
        sw_in = 4'h1;
        step(1);
        sw_in = 4'h3;
        push(0, 4'h3, 4'h2, 4'h0);
        step(8);

        // simultaneous rise/fall across bits
        sw_in = 4'h8;
        push(0, 4'h8, 4'h8, 4'h3);
        step(8);
        sw_in = 4'h4;
        push(0, 4'h4, 4'h4, 4'h8);
        step(8);

        // reset while bit 2 is partway through qualification
        sw_in = 4'h0;
        push(0, 4'h0, 4'h0, 4'h4);
        step(8);
        sw_in = 4'h4;
        step(4);
        reset = 1'b1;
        #1;
        chk("mid_reset_out", 32'(sw_out), 32'h0);
        step(2);
        chk("held_reset_out", 32'(sw_out), 32'h0);
        reset = 1'b0;
        push(0, 4'h4, 4'h4, 4'h0);
        step(8);

        // inverted instance
        rst_b = 1'b0;
        push(1, 4'hF, 4'hF, 4'h0);
        step(8);
        sw_in_b = 4'h8;
        push(1, 4'h7, 4'h0, 4'h8);
        step(8);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
